// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 architecture definitions: opcodes, sequencer states and fetch constants.
package arch_defs_pkg;

    localparam int MAX_STEPS       = 8;
    localparam int BYTES_PER_FETCH = 4;

    typedef enum logic [7:0] {
        OP_NOP   = 8'h00,
        OP_STA   = 8'h32,
        OP_LDA   = 8'h3A,
        OP_MVI_A = 8'h3E,
        OP_HLT   = 8'h76,
        OP_ADD_C = 8'h81,
        OP_XRA_C = 8'hA9,
        OP_JMP   = 8'hC3
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH_ADDR,
        S_FETCH_READ,
        S_FETCH_LATCH,
        S_CHK_MORE_BYTES,
        S_EXECUTE,
        S_LATCH,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/seq_step_counter.sv
// Loadable down-counter for execute microsteps; exposes the up-counting step index.
module seq_step_counter #(
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic              clr,
    input  logic [STEP_W:0]   load_val,
    output logic [STEP_W-1:0] step,
    output logic              done
);

    logic [STEP_W:0]   remain_reg;
    logic [STEP_W-1:0] step_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remain_reg <= '0;
            step_reg   <= '0;
        end else if (clr) begin
            remain_reg <= '0;
            step_reg   <= '0;
        end else if (load) begin
            remain_reg <= load_val;
            step_reg   <= '0;
        end else if (en && (remain_reg != '0)) begin
            remain_reg <= remain_reg - 1'b1;
            step_reg   <= step_reg + 1'b1;
        end
    end

    // Done on the last remaining step so the FSM leaves EXECUTE on that edge.
    assign done = (remain_reg == (STEP_W+1)'(1));
    assign step = step_reg;

endmodule

// File: rtl/instr_cycle_sequencer.sv
// SAP-2 instruction-cycle FSM: byte fetch, execute microsteps and result latch strobes.
module instr_cycle_sequencer #(
    parameter int MAX_STEPS = arch_defs_pkg::MAX_STEPS,
    parameter int STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        opcode_i,
    input  logic [1:0]        instr_len_i,
    input  logic [STEP_W:0]   exec_len_i,
    input  logic              mem_ready_i,
    output logic              pc_to_mar_o,
    output logic              mem_rd_o,
    output logic              ir_load_o,
    output logic              temp1_load_o,
    output logic              temp2_load_o,
    output logic              pc_inc_o,
    output logic              exec_o,
    output logic [STEP_W-1:0] step_o,
    output logic              latch_o,
    output logic              halted_o,
    output logic              illegal_o
);

    import arch_defs_pkg::*;

    localparam logic [STEP_W:0] EXEC_MAX = (STEP_W+1)'(MAX_STEPS);

    seq_state_t        state_reg, state_next;
    logic [1:0]        byte_cnt_reg, byte_cnt_next;
    logic [1:0]        len_reg, len_next;
    logic              illegal_reg, illegal_next;
    logic              run_reg;
    logic [1:0]        eff_len, byte_plus;
    logic              cnt_load, cnt_en, cnt_clr, step_done;
    logic [STEP_W-1:0] step_idx;
    logic [2:0]        byte_load;

    // run_reg holds the first fetch off until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_FETCH_ADDR;
            byte_cnt_reg <= '0;
            len_reg      <= '0;
            illegal_reg  <= 1'b0;
            run_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            len_reg      <= len_next;
            illegal_reg  <= illegal_next;
            run_reg      <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        len_next      = len_reg;
        illegal_next  = illegal_reg;
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;
        cnt_clr       = 1'b0;
        byte_plus     = byte_cnt_reg + 2'd1;
        // Length is only trusted from the decoder while IR holds byte 1.
        eff_len       = (byte_cnt_reg == 2'd0) ? instr_len_i : len_reg;
        case (state_reg)
            S_FETCH_ADDR:  if (run_reg) state_next = S_FETCH_READ;
            S_FETCH_READ:  if (mem_ready_i) state_next = S_FETCH_LATCH;
            S_FETCH_LATCH: state_next = S_CHK_MORE_BYTES;
            S_CHK_MORE_BYTES: begin
                byte_cnt_next = byte_plus;
                if (byte_cnt_reg == 2'd0) len_next = instr_len_i;
                if ((eff_len == 2'd0) || (exec_len_i > EXEC_MAX)) begin
                    illegal_next = 1'b1;
                    state_next   = S_HALT;
                end else if (opcode_i == OP_HLT) begin
                    state_next = S_HALT;
                end else if (byte_plus < eff_len) begin
                    state_next = S_FETCH_ADDR;
                end else if (exec_len_i == '0) begin
                    state_next = S_LATCH;
                end else begin
                    state_next = S_EXECUTE;
                    cnt_load   = 1'b1;
                end
            end
            S_EXECUTE: begin
                cnt_en = 1'b1;
                if (step_done) state_next = S_LATCH;
            end
            S_LATCH: begin
                cnt_clr       = 1'b1;
                byte_cnt_next = '0;
                state_next    = S_FETCH_ADDR;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH_ADDR;
        endcase
    end

    seq_step_counter #(.STEP_W(STEP_W)) u_step (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .load_val (exec_len_i),
        .step     (step_idx),
        .done     (step_done)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_byte_load
        assign byte_load[gi] = (state_reg == S_FETCH_LATCH) && (byte_cnt_reg == 2'(gi));
    end

    assign pc_to_mar_o  = run_reg && (state_reg == S_FETCH_ADDR);
    assign mem_rd_o     = (state_reg == S_FETCH_READ);
    assign ir_load_o    = byte_load[0];
    assign temp1_load_o = byte_load[1];
    assign temp2_load_o = byte_load[2];
    assign pc_inc_o     = (state_reg == S_FETCH_LATCH);
    assign exec_o       = (state_reg == S_EXECUTE);
    assign step_o       = exec_o ? step_idx : '0;
    assign latch_o      = (state_reg == S_LATCH);
    assign halted_o     = (state_reg == S_HALT);
    assign illegal_o    = illegal_reg;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Scoreboard bench for instr_cycle_sequencer: per-instruction expectations vs observed strobes.
module tb_instr_cycle_sequencer;

    import arch_defs_pkg::*;

    localparam int STEP_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        opcode_i = 8'h00;
    logic [1:0]        instr_len_i = 2'd1;
    logic [STEP_W:0]   exec_len_i = '0;
    logic              mem_ready_i = 1'b1;
    logic              pc_to_mar_o, mem_rd_o, ir_load_o, temp1_load_o, temp2_load_o;
    logic              pc_inc_o, exec_o, latch_o, halted_o, illegal_o;
    logic [STEP_W-1:0] step_o;
    logic [STEP_W+9:0] all_out;

    instr_cycle_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_i     (opcode_i),
        .instr_len_i  (instr_len_i),
        .exec_len_i   (exec_len_i),
        .mem_ready_i  (mem_ready_i),
        .pc_to_mar_o  (pc_to_mar_o),
        .mem_rd_o     (mem_rd_o),
        .ir_load_o    (ir_load_o),
        .temp1_load_o (temp1_load_o),
        .temp2_load_o (temp2_load_o),
        .pc_inc_o     (pc_inc_o),
        .exec_o       (exec_o),
        .step_o       (step_o),
        .latch_o      (latch_o),
        .halted_o     (halted_o),
        .illegal_o    (illegal_o)
    );

    assign all_out = {pc_to_mar_o, mem_rd_o, ir_load_o, temp1_load_o, temp2_load_o,
                      pc_inc_o, exec_o, step_o, latch_o, halted_o, illegal_o};

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        int len;
        int exec;
        int cycles;
        int rd;
        int ir_cyc;
        int t1_cyc;
        int exec_first;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_mon;

    int checks = 0, failures = 0;
    int done_cnt = 0, halt_seen = 0, halt_cyc = 0, halt_pcinc = 0, txn = 0;
    int cyc, pc_inc_cnt, ir_cnt, ir_first, t1_cnt, t1_first, t2_cnt, exec_cnt, exec_first, rd_cnt;
    int stall_byte = 0, stall_left = 0, stall_req_byte = 0, stall_req_n = 0;
    bit in_instr = 0, addr_pending = 0, halted_prev = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Drives instruction inputs and, for instructions that should complete, queues the expectation.
    task automatic issue(input logic [7:0] op, input int len, input int ex,
                         input int sb, input int sn, input bit track);
        exp_t e;
        if (sb >= len) sn = 0;
        opcode_i       = op;
        instr_len_i    = 2'(len);
        exec_len_i     = (STEP_W+1)'(ex);
        stall_req_byte = sb;
        stall_req_n    = sn;
        if (track) begin
            e.op         = op;
            e.len        = len;
            e.exec       = ex;
            e.cycles     = 4 * len + ex + 1 + sn;
            e.rd         = len + sn;
            e.ir_cyc     = 3 + ((sb == 0) ? sn : 0);
            e.t1_cyc     = (len >= 2) ? 7 + ((sb <= 1) ? sn : 0) : 0;
            e.exec_first = (ex > 0) ? 4 * len + 1 + sn : 0;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        int start = done_cnt;
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != start) begin
                ok = 1;
                break;
            end
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic wait_halt(input string tag);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (halted_o) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        #1;
        check(tag, 32'(ok), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(all_out), 0);
        reset = 1'b1;
        @(negedge clk);
        check("first_addr", 32'(pc_to_mar_o), 1);
    endtask

    // Monitor: tracks the current instruction, checks strobes, pops expectations on latch_o,
    // and throttles mem_ready_i for the requested stall.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_instr && sb_q.size() > 0) void'(sb_q.pop_front());
            in_instr     = 0;
            addr_pending = 0;
            halted_prev  = 0;
            mem_ready_i  = 1'b1;
        end else begin
            if (addr_pending) begin
                check("next_addr", 32'(pc_to_mar_o), 1);
                addr_pending = 0;
            end
            if (pc_to_mar_o && !in_instr) begin
                in_instr = 1;
                cyc = 0; pc_inc_cnt = 0; ir_cnt = 0; ir_first = 0; t1_cnt = 0; t1_first = 0;
                t2_cnt = 0; exec_cnt = 0; exec_first = 0; rd_cnt = 0;
                stall_byte = stall_req_byte;
                stall_left = stall_req_n;
            end
            if (in_instr) begin
                cyc++;
                if (pc_inc_o) pc_inc_cnt++;
                if (ir_load_o) begin ir_cnt++; if (ir_first == 0) ir_first = cyc; end
                if (temp1_load_o) begin t1_cnt++; if (t1_first == 0) t1_first = cyc; end
                if (temp2_load_o) t2_cnt++;
                if (ir_load_o || temp1_load_o || temp2_load_o)
                    check("load_onehot", 32'($countones({ir_load_o, temp1_load_o, temp2_load_o}) > 1), 0);
                if (mem_rd_o) begin
                    rd_cnt++;
                    check("read_quiet", 32'({pc_to_mar_o, ir_load_o, temp1_load_o, temp2_load_o,
                                             pc_inc_o, exec_o, latch_o}), 0);
                end
                if (exec_o) begin
                    check("step_idx", 32'(step_o), 32'(exec_cnt));
                    if (exec_cnt == 0) exec_first = cyc;
                    exec_cnt++;
                end
                if (latch_o) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_latch", 1, 0);
                    end else begin
                        exp_mon = sb_q.pop_front();
                        txn++;
                        $display("txn %0d: op=%02h len=%0d exec=%0d cycles=%0d (exp %0d)",
                                 txn, exp_mon.op, exp_mon.len, exp_mon.exec, cyc, exp_mon.cycles);
                        check("cycles", 32'(cyc), 32'(exp_mon.cycles));
                        check("pc_inc_cnt", 32'(pc_inc_cnt), 32'(exp_mon.len));
                        check("ir_cnt", 32'(ir_cnt), 1);
                        check("ir_cyc", 32'(ir_first), 32'(exp_mon.ir_cyc));
                        check("t1_cnt", 32'(t1_cnt), 32'(exp_mon.len >= 2));
                        check("t1_cyc", 32'(t1_first), 32'(exp_mon.t1_cyc));
                        check("t2_cnt", 32'(t2_cnt), 32'(exp_mon.len == 3));
                        check("exec_cnt", 32'(exec_cnt), 32'(exp_mon.exec));
                        check("exec_first", 32'(exec_first), 32'(exp_mon.exec_first));
                        check("rd_cnt", 32'(rd_cnt), 32'(exp_mon.rd));
                        check("illegal_clear", 32'(illegal_o), 0);
                    end
                    done_cnt++;
                    in_instr     = 0;
                    addr_pending = 1;
                end
            end
            if (halted_o && !halted_prev) begin
                halt_cyc   = in_instr ? cyc : 0;
                halt_pcinc = pc_inc_cnt;
                halt_seen++;
                in_instr   = 0;
            end
            halted_prev = halted_o;
            mem_ready_i = 1'b1;
            if (in_instr && mem_rd_o && pc_inc_cnt == stall_byte && stall_left > 0) begin
                mem_ready_i = 1'b0;
                stall_left--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int start, rd, lost;
        bit found;

        issue(OP_MVI_A, 2, 1, 0, 0, 1);
        do_reset();
        wait_done("ldi_a_done");
        issue(OP_XRA_C, 1, 2, 0, 0, 1);
        wait_done("xra_c_done");
        issue(OP_ADD_C, 1, 2, 0, 0, 1);
        wait_done("add_c_done");
        issue(OP_STA, 3, 1, 1, 3, 1);
        wait_done("sta_stall_done");
        issue(OP_JMP, 3, 0, 0, 0, 1);
        wait_done("jmp_done");
        issue(OP_NOP, 1, 0, 0, 0, 1);
        wait_done("nop_done");
        issue(OP_ADD_C, 1, 8, 0, 0, 1);
        wait_done("max_exec_done");
        issue(OP_LDA, 3, 2, 0, 2, 1);
        wait_done("lda_stall0_done");
        for (int i = 0; i < 6; i++) begin
            issue(OP_ADD_C, int'($urandom_range(1, 3)), int'($urandom_range(0, 8)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1);
            wait_done("rand_done");
        end

        // HLT: halts one cycle after CHK, PC still incremented, then stays put.
        issue(OP_HLT, 1, 1, 0, 0, 0);
        wait_halt("hlt_halt");
        check("hlt_cyc", 32'(halt_cyc), 5);
        check("hlt_pc_inc", 32'(halt_pcinc), 1);
        check("hlt_not_illegal", 32'(illegal_o), 0);
        rd = 0;
        lost = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_rd_o) rd++;
            if (!halted_o) lost++;
        end
        check("hlt_no_rd", 32'(rd), 0);
        check("hlt_stuck", 32'(lost), 0);
        issue(OP_MVI_A, 2, 1, 0, 0, 1);
        do_reset();
        wait_done("restart_done");

        // Illegal length.
        start = done_cnt;
        issue(OP_ADD_C, 0, 1, 0, 0, 0);
        do_reset();
        wait_halt("len0_halt");
        check("len0_illegal", 32'(illegal_o), 1);
        check("len0_halt_cyc", 32'(halt_cyc), 5);
        repeat (20) @(negedge clk);
        check("len0_no_latch", 32'(done_cnt), 32'(start));

        // Illegal microstep count.
        issue(OP_ADD_C, 1, 9, 0, 0, 0);
        do_reset();
        wait_halt("exec9_halt");
        check("exec9_illegal", 32'(illegal_o), 1);
        check("exec9_halted", 32'(halted_o), 1);
        repeat (20) @(negedge clk);
        check("exec9_no_latch", 32'(done_cnt), 32'(start));

        // Asynchronous abort during execute step 1, then a clean fetch.
        issue(OP_MVI_A, 2, 1, 0, 0, 1);
        do_reset();
        wait_done("post_illegal_done");
        issue(OP_XRA_C, 1, 4, 0, 0, 1);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exec_o && step_o == 3'd1) begin
                found = 1;
                break;
            end
        end
        check("reach_step1", 32'(found), 1);
        #2 reset = 1'b0;
        #1 check("async_reset", 32'(all_out), 0);
        issue(OP_MVI_A, 2, 1, 0, 0, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_first_addr", 32'(pc_to_mar_o), 1);
        wait_done("post_abort_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
